// File: rtl/mux_pkg.sv
// Shared constants and types for the N:1 streaming multiplexer family.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_N     = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting at ptr_i, wrapping mod N,
// and returns the first requester as both a one-hot grant and an encoded index.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  // Priority scan over the rotated request vector; the first hit wins.
  always_comb begin
    int idx;
    gnt_o       = {N{1'b0}};
    gnt_idx_o   = {SELW{1'b0}};
    gnt_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = SELW'(idx);
        gnt_valid_o = 1'b1;
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N:1 valid/ready stream multiplexer with fixed-select or round-robin grant and a
// one-entry registered output stage (1-cycle latency, full throughput).
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = DEFAULT_N,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
);

  out_state_e        state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]      rr_gnt_s;
  logic [SELW-1:0]   rr_idx_s;
  logic              rr_valid_s;

  logic              fix_valid_s;
  logic [N-1:0]      gnt_oh_s;
  logic [SELW-1:0]   gnt_idx_s;
  logic              gnt_valid_s;
  logic              load_en_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  beat_s;

  rr_arbiter #(
    .N(N)
  ) u_rr_arbiter (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (rr_gnt_s),
    .gnt_idx_o   (rr_idx_s),
    .gnt_valid_o (rr_valid_s)
  );

  // Grant selection; an out-of-range sel (non-power-of-2 N) never grants.
  always_comb begin
    fix_valid_s = 1'b0;
    if (int'(sel) < N) begin
      fix_valid_s = in_valid[sel];
    end else begin
      fix_valid_s = 1'b0;
    end

    if (mode == MODE_RR) begin
      gnt_oh_s    = rr_gnt_s;
      gnt_idx_s   = rr_idx_s;
      gnt_valid_s = rr_valid_s;
    end else begin
      gnt_oh_s    = fix_valid_s ? ({{(N-1){1'b0}}, 1'b1} << sel) : {N{1'b0}};
      gnt_idx_s   = sel;
      gnt_valid_s = fix_valid_s;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

  assign load_en_s = !out_valid || out_ready;
  assign xfer_s    = !rst && load_en_s && gnt_valid_s;
  assign in_ready  = xfer_s ? gnt_oh_s : {N{1'b0}};

  // Data path mux for the granted channel.
  always_comb begin
    beat_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (gnt_idx_s == SELW'(i)) begin
        beat_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        beat_s = beat_s;
      end
    end
  end

  // Output register FSM and next-state for data, channel and round-robin pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;

    case (state_q)
      EMPTY: begin
        if (xfer_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer_s) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (xfer_s) begin
      data_d = beat_s;
      ch_d   = gnt_idx_s;
    end else begin
      data_d = data_q;
      ch_d   = ch_q;
    end

    if (xfer_s && (mode == MODE_RR)) begin
      ptr_d = (int'(gnt_idx_s) == N - 1) ? {SELW{1'b0}} : gnt_idx_s + SELW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; a reset discards any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= {WIDTH{1'b0}};
      ch_q    <= {SELW{1'b0}};
      ptr_q   <= {SELW{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: doc/mux_nto1_stream.md
Name: mux_nto1_stream

Overview:
Parametrised N:1 streaming multiplexer that succeeds the plain 2:1 mux used in the combinational library. Each of N input channels carries data with a valid/ready handshake. The block selects one channel per cycle, either by fixed select or by round-robin arbitration. The chosen beat goes into a one-entry output register, so the output is registered with 1-cycle latency and full throughput.

Parameters:
WIDTH, 8, data bits per channel
N, 4, number of input channels (>= 2)
SELW, $clog2(N), select/channel-index width (derived localparam, not overridable)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready, one-hot or zero
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used when mode=0
out_data  output  WIDTH  registered output beat
out_valid  output  1  output register holds a beat
out_ready  input  1  downstream accepts beat
out_ch  output  SELW  source channel of current out_data

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0, in_ready=0 during the rst cycle.
- Output register FSM, 2 states:
  - EMPTY (out_valid=0): goes to FULL on load.
  - FULL (out_valid=1): stays FULL on load while draining. Goes to EMPTY when out_ready=1 and no load. Holds when out_ready=0.
- load_en = !out_valid || out_ready. New beats are accepted in the same cycle the old beat drains, so back-to-back throughput is 1 beat/cycle.
- Grant selection (combinational, evaluated every cycle):
  - mode=0: grant channel sel if in_valid[sel]=1, otherwise no grant. If sel >= N (non-power-of-2 N), no grant.
  - mode=1: grant the first i with in_valid[i]=1, scanning ptr, ptr+1, … mod N. No grant if all in_valid=0.
- in_ready[g] = load_en && grant valid, for the granted g only. All other in_ready bits are 0. in_ready never depends on in_valid of other channels beyond the grant.
- Transfer on input: in_valid[g] && in_ready[g]. The register loads out_data=in_data[g], out_ch=g, out_valid=1 on the next edge. Latency is input handshake → out_valid = 1 cycle.
- While out_valid=1 and out_ready=0, out_data and out_ch are held stable.
- ptr updates only on an accepted input transfer in mode=1: ptr <= (g+1) mod N, wrapping N-1 → 0. ptr is unchanged in mode=0 and in cycles without a transfer.
- mode/sel changes act on the next grant only and never alter a held beat.
- Reset mid-operation: any held beat is discarded and no in_ready is asserted in that cycle.

Decomposition:
- Shared package (mux_pkg): default WIDTH/N constants, MODE_FIXED=1'b0 and MODE_RR=1'b1 constants, 2-state enum {EMPTY, FULL}.
- One natural sub-module: rr_arbiter (N-bit request, ptr in, one-hot grant + encoded index out, purely combinational). It is reused by future arbitrated blocks.
- The output register and handshake stay in the top.

Test Plan:
- Reset/idle: assert rst with in_valid=4'b1111 → out_valid=0, out_data=8'h00, in_ready=4'b0000. After release and one cycle, out_valid=1.
- Fixed mode: mode=0, sel=2, in_valid=4'b0110, ch1=8'hA1, ch2=8'hB2, out_ready=1 → in_ready=4'b0100, next cycle out_data=8'hB2, out_ch=2. Then sel=3 with in_valid[3]=0 → in_ready=0, out_valid drops the following cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1, ch i data=8'h10+i → out_ch sequence 0,1,2,3,0 on consecutive cycles, out_data 8'h10,11,12,13,10. Wrap covers 3 → 0.
- Skipping and sparse requests: mode=1, ptr=1, in_valid=4'b1001 → grant ch3 (out_data from ch3), ptr becomes 0. Next grant is ch0.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles → in_ready=0, out_data/out_ch stable, ptr unchanged. Raise out_ready → drain and load in the same cycle with no bubble.
- Reset mid-stream: rst for 1 cycle while out_valid=1, out_ready=0 → next cycle out_valid=0, ptr=0, and the held beat is never presented.
